// File: rtl/ritc_input_pkg.sv
// Shared encodings and lane indexing for the RITC LVDS input buffer array.
package ritc_input_pkg;

  typedef enum logic [1:0] {
    CH_OFF    = 2'd0,
    CH_SETTLE = 2'd1,
    CH_ON     = 2'd2
  } ch_state_e;

  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_RUN  = 2'd1,
    MON_DONE = 2'd2
  } mon_state_e;

  // Flat pin index of lane b in channel c.
  function automatic int unsigned lane_idx(input int unsigned c, input int unsigned b,
                                           input int unsigned nbits = 12);
    return c * nbits + b;
  endfunction

endpackage

// File: rtl/ritc_channel_sequencer.sv
// Per-channel power-up sequencer: OFF -> SETTLE (counted) -> ON, with drop-to-OFF priority.
module ritc_channel_sequencer
  import ritc_input_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable_i,
  input  logic disable_i,
  output logic ready_o,
  output logic ibufdisable_o
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYCLES - 1);

  ch_state_e       r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_ready, r_ibufdisable;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    if (!enable_i || disable_i) begin
      w_next = CH_OFF;
    end else begin
      case (r_state)
        CH_OFF: begin
          w_next     = CH_SETTLE;
          w_cnt_next = '0;
        end
        CH_SETTLE: begin
          if (r_cnt == LAST_CNT) w_next = CH_ON;
          else                   w_cnt_next = r_cnt + CW'(1);
        end
        CH_ON:   w_next = CH_ON;
        default: w_next = CH_OFF;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= CH_OFF;
      r_cnt         <= '0;
      r_ready       <= 1'b0;
      r_ibufdisable <= 1'b1;
    end else begin
      r_state       <= w_next;
      r_cnt         <= w_cnt_next;
      r_ready       <= (w_next == CH_ON);
      r_ibufdisable <= (w_next == CH_OFF);
    end
  end

  assign ready_o       = r_ready;
  assign ibufdisable_o = r_ibufdisable;

endmodule

// File: rtl/ritc_input_buffer_array.sv
// RITC LVDS front end: gated differential input buffers, per-channel sequencers and a
// windowed lane-activity monitor that flags stuck data lanes and channel clocks.
module ritc_input_buffer_array
  import ritc_input_pkg::*;
#(
  parameter int NCH           = 3,
  parameter int NBITS         = 12,
  parameter int SETTLE_CYCLES = 64,
  parameter int WINDOW_LOG2   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 disable_i,
  input  logic [NCH-1:0]       enable_i,
  output logic [NCH-1:0]       ready_o,
  input  logic [NCH*NBITS-1:0] DATA_P,
  input  logic [NCH*NBITS-1:0] DATA_N,
  output logic [NCH*NBITS-1:0] DATA,
  output logic [NCH*NBITS-1:0] DATA_B,
  input  logic [NCH-1:0]       CLK_P,
  input  logic [NCH-1:0]       CLK_N,
  output logic [NCH-1:0]       CLK,
  output logic [NCH-1:0]       CLK_B,
  input  logic                 mon_start_i,
  output logic                 mon_busy_o,
  output logic                 mon_done_o,
  output logic [NCH-1:0]       mon_valid_o,
  output logic [NCH*NBITS-1:0] stuck_o,
  output logic [NCH-1:0]       clk_stuck_o
);

  localparam int LANES = NCH * NBITS;
  localparam int MON_W = LANES + NCH;

  logic [NCH-1:0]   w_ibufdis;
  logic [NCH-1:0]   w_ready;
  logic [LANES-1:0] w_valid_lanes;
  logic [NCH-1:0]   w_valid_acc;

  // Buffer model of IBUFDS_DIFF_OUT_IBUFDISABLE: both outputs forced high while disabled.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    ritc_channel_sequencer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_seq (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .enable_i     (enable_i[c]),
      .disable_i    (disable_i),
      .ready_o      (w_ready[c]),
      .ibufdisable_o(w_ibufdis[c])
    );

    logic w_clk_diff;
    assign w_clk_diff = CLK_P[c] & ~CLK_N[c];
    assign CLK[c]     = w_ibufdis[c] | w_clk_diff;
    assign CLK_B[c]   = w_ibufdis[c] | ~w_clk_diff;

    for (genvar b = 0; b < NBITS; b++) begin : g_lane
      localparam int L = lane_idx(c, b, NBITS);
      logic w_diff;
      assign w_diff           = DATA_P[L] & ~DATA_N[L];
      assign DATA[L]          = w_ibufdis[c] | w_diff;
      assign DATA_B[L]        = w_ibufdis[c] | ~w_diff;
      assign w_valid_lanes[L] = w_valid_acc[c];
    end
  end

  assign ready_o = w_ready;

  // Activity monitor: pins -> 2-flop synchroniser -> edge register.
  logic [MON_W-1:0]       r_sync1, r_sync2, r_edge, r_seen;
  logic [MON_W-1:0]       w_mon_in, w_trans, w_seen_acc;
  logic [NCH-1:0]         r_valid, r_mon_valid, r_clk_stuck;
  logic [LANES-1:0]       r_stuck;
  logic [WINDOW_LOG2-1:0] r_win;
  logic                   w_win_last;
  mon_state_e             r_mon_state, w_mon_next;

  assign w_mon_in    = {CLK, DATA};
  assign w_trans     = r_sync2 ^ r_edge;
  assign w_seen_acc  = r_seen | w_trans;
  assign w_valid_acc = r_valid & w_ready;
  assign w_win_last  = &r_win;

  always_comb begin
    w_mon_next = r_mon_state;
    case (r_mon_state)
      MON_IDLE: if (mon_start_i) w_mon_next = MON_RUN;
      MON_RUN:  if (w_win_last)  w_mon_next = MON_DONE;
      MON_DONE: w_mon_next = MON_IDLE;
      default:  w_mon_next = MON_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_mon_state <= MON_IDLE;
    else          r_mon_state <= w_mon_next;
  end

  // NOTE: the synchroniser and seen vectors are reset too, so a mid-window reset leaves no stale activity.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_edge      <= '0;
      r_seen      <= '0;
      r_valid     <= '0;
      r_win       <= '0;
      r_mon_valid <= '0;
      r_stuck     <= '0;
      r_clk_stuck <= '0;
    end else begin
      r_sync1 <= w_mon_in;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
      case (r_mon_state)
        MON_IDLE: begin
          if (mon_start_i) begin
            r_seen  <= '0;
            r_win   <= '0;
            r_valid <= w_ready;
          end
        end
        MON_RUN: begin
          r_seen  <= w_seen_acc;
          r_valid <= w_valid_acc;
          r_win   <= r_win + WINDOW_LOG2'(1);
          // Results land together with the done pulse and include the final window cycle.
          if (w_win_last) begin
            r_stuck     <= ~w_seen_acc[LANES-1:0] & w_valid_lanes;
            r_clk_stuck <= ~w_seen_acc[MON_W-1:LANES] & w_valid_acc;
            r_mon_valid <= w_valid_acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign mon_busy_o  = (r_mon_state == MON_RUN);
  assign mon_done_o  = (r_mon_state == MON_DONE);
  assign mon_valid_o = r_mon_valid;
  assign stuck_o     = r_stuck;
  assign clk_stuck_o = r_clk_stuck;

endmodule

// File: tb/tb_ritc_input_buffer_array.sv
// Directed bench for ritc_input_buffer_array: sequencing, buffer gating and stuck-lane monitor.
module tb_ritc_input_buffer_array;

  localparam int NCH   = 3;
  localparam int NBITS = 12;
  localparam int LANES = NCH * NBITS;
  localparam int SETTLE = 64;
  localparam int WLOG  = 4;
  localparam logic [LANES-1:0] ALL1 = '1;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             disable_i;
  logic [NCH-1:0]   enable_i;
  logic [NCH-1:0]   ready_o;
  logic [LANES-1:0] DATA_P, DATA_N, DATA, DATA_B;
  logic [NCH-1:0]   CLK_P, CLK_N, CLK, CLK_B;
  logic             mon_start_i, mon_busy_o, mon_done_o;
  logic [NCH-1:0]   mon_valid_o, clk_stuck_o;
  logic [LANES-1:0] stuck_o;

  ritc_input_buffer_array #(
    .NCH(NCH), .NBITS(NBITS), .SETTLE_CYCLES(SETTLE), .WINDOW_LOG2(WLOG)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .disable_i(disable_i), .enable_i(enable_i),
    .ready_o(ready_o), .DATA_P(DATA_P), .DATA_N(DATA_N), .DATA(DATA), .DATA_B(DATA_B),
    .CLK_P(CLK_P), .CLK_N(CLK_N), .CLK(CLK), .CLK_B(CLK_B),
    .mon_start_i(mon_start_i), .mon_busy_o(mon_busy_o), .mon_done_o(mon_done_o),
    .mon_valid_o(mon_valid_o), .stuck_o(stuck_o), .clk_stuck_o(clk_stuck_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  logic [LANES-1:0] hold_mask = '0;
  logic [NCH-1:0]   clk_hold  = '0;
  bit               tog_en    = 1'b0;

  typedef struct {
    logic [LANES-1:0] p;
    logic [NCH-1:0]   cp;
    logic [LANES-1:0] exp_o;
    logic [LANES-1:0] exp_ob;
    logic [NCH-1:0]   exp_c;
    logic [NCH-1:0]   exp_cb;
  } buf_vec_t;

  buf_vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pins(input logic [LANES-1:0] p, input logic [NCH-1:0] cp);
    DATA_P = p;
    DATA_N = ~p;
    CLK_P  = cp;
    CLK_N  = ~cp;
  endtask

  // Advance one edge, sample point is 1 time unit after it; optionally toggle non-held pins.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (tog_en) set_pins(DATA_P ^ ~hold_mask, CLK_P ^ ~clk_hold);
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ready_o == '0 && n < max);
  endtask

  task automatic pulse_start();
    mon_start_i = 1'b1;
    tick();
    mon_start_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int dones;

    // Ch1 enabled, ch0/ch2 disabled: only bits 23:12 and CLK[1] follow the pins.
    vecs[0] = '{36'h000000000, 3'b000, 36'hFFF000FFF, 36'hFFFFFFFFF, 3'b101, 3'b111};
    vecs[1] = '{36'h123456789, 3'b010, 36'hFFF456FFF, 36'hFFFBA9FFF, 3'b111, 3'b101};
    vecs[2] = '{36'hFFFFFFFFF, 3'b101, 36'hFFFFFFFFF, 36'hFFF000FFF, 3'b101, 3'b111};
    vecs[3] = '{36'hABCDEF012, 3'b111, 36'hFFFDEFFFF, 36'hFFF210FFF, 3'b111, 3'b101};

    rst_n_i     = 1'b0;
    disable_i   = 1'b0;
    enable_i    = '0;
    mon_start_i = 1'b0;
    set_pins('0, '0);
    repeat (3) tick();
    rst_n_i = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_ready", ready_o, 0);
    check("rst_busy", mon_busy_o, 0);
    check("rst_done", mon_done_o, 0);
    check("rst_valid", mon_valid_o, 0);
    check("rst_stuck", stuck_o, 0);
    check("rst_clk_stuck", clk_stuck_o, 0);
    check("rst_data_disabled", DATA, ALL1);
    check("rst_datab_disabled", DATA_B, ALL1);
    check("rst_clk_disabled", CLK, 3'b111);

    // Enable ch1: buffer on at edge 1, ready at edge 1+SETTLE
    enable_i = 3'b010;
    tick();
    check("en1_ibuf_edge1", DATA, 36'hFFF000FFF);
    check("en1_ready_edge1", ready_o, 0);
    wait_ready(200, n);
    check("en1_ready_edge", n + 1, SETTLE + 1);
    check("en1_ready_val", ready_o, 3'b010);

    for (int i = 0; i < 4; i++) begin
      set_pins(vecs[i].p, vecs[i].cp);
      #1;
      check($sformatf("buf_o_%0d", i), DATA, vecs[i].exp_o);
      check($sformatf("buf_ob_%0d", i), DATA_B, vecs[i].exp_ob);
      check($sformatf("buf_c_%0d", i), CLK, vecs[i].exp_c);
      check($sformatf("buf_cb_%0d", i), CLK_B, vecs[i].exp_cb);
    end

    // Drop at settle count 30, re-raise two cycles later: full restart
    set_pins('0, '0);
    enable_i = 3'b000;
    tick();
    check("drop_on_ready", ready_o, 0);
    tick();
    enable_i = 3'b010;
    repeat (31) tick();
    check("settle30_ready", ready_o, 0);
    check("settle30_ibuf_on", DATA, 36'hFFF000FFF);
    enable_i = 3'b000;
    tick();
    check("drop_settle_ready", ready_o, 0);
    check("drop_settle_ibuf", DATA, ALL1);
    tick();
    enable_i = 3'b010;
    wait_ready(200, n);
    check("reraise_ready_edge", n, SETTLE + 1);
    check("reraise_ready_val", ready_o, 3'b010);

    // Global disable with all ON, then parallel resettle
    enable_i = 3'b111;
    repeat (70) tick();
    check("all_on", ready_o, 3'b111);
    check("all_on_data", DATA, 36'h0);
    disable_i = 1'b1;
    tick();
    check("disable_ready", ready_o, 0);
    check("disable_data", DATA, ALL1);
    check("disable_clk", CLK, 3'b111);
    disable_i = 1'b0;
    wait_ready(200, n);
    check("resettle_edge", n, SETTLE + 1);
    check("resettle_val", ready_o, 3'b111);

    // Monitor: everything toggles except ch2 lane 5 (bit 29)
    set_pins('0, '0);
    hold_mask = 36'h020000000;
    clk_hold  = 3'b000;
    tog_en    = 1'b1;
    repeat (5) tick();
    pulse_start();
    check("mon_busy_edge1", mon_busy_o, 1);
    n = 1;
    while (!mon_done_o && n < 40) begin
      tick();
      n++;
    end
    check("mon_done_edge", n, (1 << WLOG) + 1);
    check("mon_busy_at_done", mon_busy_o, 0);
    check("mon_valid", mon_valid_o, 3'b111);
    check("mon_stuck", stuck_o, 36'h020000000);
    check("mon_clk_stuck", clk_stuck_o, 0);
    tick();
    check("mon_done_one_cycle", mon_done_o, 0);
    check("mon_stuck_hold", stuck_o, 36'h020000000);

    // Monitor: ch0 static and dropped mid-window; second start ignored
    tog_en = 1'b0;
    set_pins(36'h000000FFF, 3'b001);
    hold_mask = 36'h020000FFF;
    clk_hold  = 3'b001;
    tog_en    = 1'b1;
    repeat (5) tick();
    pulse_start();
    n = 1;
    while (!mon_done_o && n < 40) begin
      if (n == 5) enable_i = 3'b110;
      mon_start_i = (n == 8);
      tick();
      n++;
    end
    mon_start_i = 1'b0;
    check("drop_mon_done_edge", n, (1 << WLOG) + 1);
    check("drop_mon_valid", mon_valid_o, 3'b110);
    check("drop_mon_stuck_ch0", stuck_o[11:0], 0);
    check("drop_mon_stuck", stuck_o, 36'h020000000);
    check("drop_mon_clk_stuck", clk_stuck_o, 0);
    repeat (3) tick();
    check("second_start_ignored", mon_busy_o, 0);

    // Reset mid-window aborts and clears
    enable_i = 3'b111;
    pulse_start();
    repeat (5) tick();
    rst_n_i = 1'b0;
    #1;
    check("rstmid_busy", mon_busy_o, 0);
    check("rstmid_valid", mon_valid_o, 0);
    check("rstmid_stuck", stuck_o, 0);
    check("rstmid_ready", ready_o, 0);
    check("rstmid_data", DATA, ALL1);
    tick();
    rst_n_i = 1'b1;
    dones = 0;
    repeat (30) begin
      tick();
      if (mon_done_o) dones++;
    end
    check("rstmid_no_done", dones, 0);
    check("rstmid_valid_after", mon_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
